// File: rtl/combi_mode_ctrl.sv
// combi_mode_ctrl: sequences ARM <-> RISC-V mode switches for the combined
// pipeline. Once a switch request is accepted it stalls fetch and bubbles
// decode until the older instructions have drained. It then flips `arm`
// and resumes.
// Optional feature: define COMBI_SWITCH_CNT_EN to add the SwitchCount
// output, a saturating count of completed switches.
module combi_mode_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,   // legal range 1..15
    parameter bit          RESET_ARM    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SwitchReqF,
    input  logic        SwitchTargetF,
    input  logic        HoldP,
    input  logic        BranchTakenE,
    output logic        arm,
    output logic        StallF,
    output logic        FlushD,
    output logic        SwitchAck,
    output logic        SwitchAbort,
    output logic        Busy
`ifdef COMBI_SWITCH_CNT_EN
    ,
    output logic [15:0] SwitchCount
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    // The DRAIN phase ends on the cycle in which cnt is 0. Loading
    // DRAIN_CYCLES-1 therefore gives exactly DRAIN_CYCLES non-held cycles.
    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       tgt;

    logic req_ok;
    logic accept;
    logic noop;

    // Qualify a fetch request. Requests are only considered in RUN while the
    // pipeline is not held.
    assign req_ok = (state == ST_RUN) && SwitchReqF && !HoldP;
    assign accept = req_ok && (SwitchTargetF != arm);
    assign noop   = req_ok && (SwitchTargetF == arm);

    // Output decode. In DRAIN and SWAP the outputs follow the state. In RUN
    // they follow the request, so fetch stalls in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        StallF      = 1'b0;
        FlushD      = 1'b0;
        SwitchAck   = 1'b0;
        SwitchAbort = 1'b0;
        Busy        = 1'b0;
        unique case (state)
            ST_RUN: begin
                StallF    = accept;
                SwitchAck = noop;
            end
            ST_DRAIN: begin
                FlushD      = 1'b1;
                Busy        = 1'b1;
                // A taken older branch releases fetch at once so the redirect proceeds.
                StallF      = !BranchTakenE;
                SwitchAbort = BranchTakenE;
            end
            ST_SWAP: begin
                StallF    = 1'b1;
                FlushD    = 1'b1;
                Busy      = 1'b1;
                SwitchAck = 1'b1;
            end
            default: ;
        endcase
    end

    // Switch sequencer. Reset has priority over everything. `arm` only
    // changes on reset or when leaving SWAP.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= ST_RUN;
            cnt   <= 4'd0;
            tgt   <= 1'b0;
            arm   <= RESET_ARM;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (accept) begin
                        tgt   <= SwitchTargetF;
                        cnt   <= CNT_INIT;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (BranchTakenE) begin
                        state <= ST_RUN;
                    end else if (!HoldP) begin
                        if (cnt == 4'd0) begin
                            state <= ST_SWAP;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                ST_SWAP: begin
                    arm   <= tgt;
                    state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef COMBI_SWITCH_CNT_EN
    logic [15:0] switch_cnt;

    // Count completed switches. No-op acks and aborts never reach SWAP, so
    // they are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            switch_cnt <= 16'd0;
        end else if ((state == ST_SWAP) && (switch_cnt != 16'hFFFF)) begin
            switch_cnt <= switch_cnt + 16'd1;
        end
    end

    assign SwitchCount = switch_cnt;
`endif

endmodule

// File: tb/tb_combi_mode_ctrl.sv
// Self-checking bench for combi_mode_ctrl. A per-cycle behavioural model
// checks every output on each falling edge. Directed scenarios add literal
// expectations taken from hand-worked timelines.
module tb_combi_mode_ctrl;

    localparam int unsigned DRAIN     = 4;
    localparam bit          RESET_ARM = 1'b0;

    logic clk = 1'b0;
    logic reset, SwitchReqF, SwitchTargetF, HoldP, BranchTakenE;
    logic arm, StallF, FlushD, SwitchAck, SwitchAbort, Busy;
`ifdef COMBI_SWITCH_CNT_EN
    logic [15:0] SwitchCount;
`endif

    int checks = 0;
    int errors = 0;

    combi_mode_ctrl #(.DRAIN_CYCLES(DRAIN), .RESET_ARM(RESET_ARM)) dut (
        .clk          (clk),
        .reset        (reset),
        .SwitchReqF   (SwitchReqF),
        .SwitchTargetF(SwitchTargetF),
        .HoldP        (HoldP),
        .BranchTakenE (BranchTakenE),
        .arm          (arm),
        .StallF       (StallF),
        .FlushD       (FlushD),
        .SwitchAck    (SwitchAck),
        .SwitchAbort  (SwitchAbort),
        .Busy         (Busy)
`ifdef COMBI_SWITCH_CNT_EN
        ,
        .SwitchCount  (SwitchCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The controller is in one of three phases:
    //   idle   - normal operation
    //   drain  - waiting for `left` more unheld cycles
    //   swap   - the cycle in which the mode flip happens
    localparam int PH_IDLE = 0, PH_DRAIN = 1, PH_SWAP = 2;
    int          m_phase = PH_IDLE;
    int          m_left  = 0;
    bit          m_arm   = RESET_ARM;
    bit          m_tgt   = 1'b0;
    int          m_cnt   = 0;
    bit          m_valid = 1'b0;

    always @(negedge clk) begin
        bit e_stall, e_flush, e_ack, e_abort, e_busy;
        bit want_switch, want_noop;
        e_stall = 0; e_flush = 0; e_ack = 0; e_abort = 0; e_busy = 0;
        want_switch = (m_phase == PH_IDLE) && SwitchReqF && !HoldP && (SwitchTargetF != m_arm);
        want_noop   = (m_phase == PH_IDLE) && SwitchReqF && !HoldP && (SwitchTargetF == m_arm);
        if (m_phase == PH_IDLE) begin
            e_stall = want_switch;
            e_ack   = want_noop;
        end else if (m_phase == PH_DRAIN) begin
            e_busy  = 1; e_flush = 1;
            e_abort = BranchTakenE;
            e_stall = !BranchTakenE;
        end else begin
            e_busy = 1; e_flush = 1; e_stall = 1; e_ack = 1;
        end

        if (m_valid) begin
            check("model_arm",   {31'd0, arm},         {31'd0, m_arm});
            check("model_stall", {31'd0, StallF},      {31'd0, e_stall});
            check("model_flush", {31'd0, FlushD},      {31'd0, e_flush});
            check("model_ack",   {31'd0, SwitchAck},   {31'd0, e_ack});
            check("model_abort", {31'd0, SwitchAbort}, {31'd0, e_abort});
            check("model_busy",  {31'd0, Busy},        {31'd0, e_busy});
`ifdef COMBI_SWITCH_CNT_EN
            check("model_count", {16'd0, SwitchCount}, 32'(m_cnt));
`endif
        end

        // Advance the model across the coming rising edge.
        if (reset) begin
            m_phase = PH_IDLE; m_left = 0; m_arm = RESET_ARM; m_tgt = 0; m_cnt = 0;
            m_valid = 1;
        end else if (m_phase == PH_IDLE) begin
            if (want_switch) begin
                m_phase = PH_DRAIN; m_left = DRAIN; m_tgt = SwitchTargetF;
            end
        end else if (m_phase == PH_DRAIN) begin
            if (BranchTakenE) m_phase = PH_IDLE;
            else if (!HoldP) begin
                m_left--;
                if (m_left == 0) m_phase = PH_SWAP;
            end
        end else begin
            m_arm   = m_tgt;
            m_phase = PH_IDLE;
            if (m_cnt < 65535) m_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic r, input logic req, input logic tg, input logic hd, input logic br);
        @(posedge clk); #1;
        reset = r; SwitchReqF = req; SwitchTargetF = tg; HoldP = hd; BranchTakenE = br;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_switch(input logic tg);
        drive(0, 1, tg, 0, 0);
        repeat (DRAIN + 1) idle();
    endtask

    initial begin
        reset = 1; SwitchReqF = 0; SwitchTargetF = 0; HoldP = 0; BranchTakenE = 0;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // Reset state
        idle();
        check("rst_arm",   {31'd0, arm},         32'd0);
        check("rst_stall", {31'd0, StallF},      32'd0);
        check("rst_flush", {31'd0, FlushD},      32'd0);
        check("rst_ack",   {31'd0, SwitchAck},   32'd0);
        check("rst_abort", {31'd0, SwitchAbort}, 32'd0);
        check("rst_busy",  {31'd0, Busy},        32'd0);
`ifdef COMBI_SWITCH_CNT_EN
        check("rst_count", {16'd0, SwitchCount}, 32'd0);
`endif

        // Plain switch to ARM: stall t..t+5, flush t+1..t+5, ack at t+5, arm=1 at t+6
        drive(0, 1, 1, 0, 0);
        check("sw_acc_stall", {31'd0, StallF}, 32'd1);
        check("sw_acc_flush", {31'd0, FlushD}, 32'd0);
        check("sw_acc_busy",  {31'd0, Busy},   32'd0);
        for (int k = 1; k <= 5; k++) begin
            idle();
            check("sw_stall", {31'd0, StallF},    32'd1);
            check("sw_flush", {31'd0, FlushD},    32'd1);
            check("sw_busy",  {31'd0, Busy},      32'd1);
            check("sw_ack",   {31'd0, SwitchAck}, (k == 5) ? 32'd1 : 32'd0);
            check("sw_arm",   {31'd0, arm},       32'd0);
        end
        idle();
        check("sw_done_arm",   {31'd0, arm},    32'd1);
        check("sw_done_stall", {31'd0, StallF}, 32'd0);
        check("sw_done_busy",  {31'd0, Busy},   32'd0);

        // No-op request while already in ARM
        drive(0, 1, 1, 0, 0);
        check("noop_ack",   {31'd0, SwitchAck}, 32'd1);
        check("noop_stall", {31'd0, StallF},    32'd0);
        check("noop_busy",  {31'd0, Busy},      32'd0);
        idle();
        check("noop_busy_after", {31'd0, Busy}, 32'd0);
        check("noop_arm_after",  {31'd0, arm},  32'd1);

        // Switch back to RISC-V with HoldP for 3 DRAIN cycles: SWAP at t+8, arm=0 at t+9
        drive(0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, (k >= 2 && k <= 4), 0);
            check("hold_ack",  {31'd0, SwitchAck}, (k == 8) ? 32'd1 : 32'd0);
            check("hold_busy", {31'd0, Busy},      32'd1);
            check("hold_arm",  {31'd0, arm},       32'd1);
        end
        idle();
        check("hold_done_arm",  {31'd0, arm},  32'd0);
        check("hold_done_busy", {31'd0, Busy}, 32'd0);

        // Abort: taken branch at t+2
        drive(0, 1, 1, 0, 0);
        idle();
        drive(0, 0, 0, 0, 1);
        check("abort_pulse", {31'd0, SwitchAbort}, 32'd1);
        check("abort_stall", {31'd0, StallF},      32'd0);
        check("abort_ack",   {31'd0, SwitchAck},   32'd0);
        idle();
        check("abort_busy",  {31'd0, Busy},        32'd0);
        check("abort_arm",   {31'd0, arm},         32'd0);
        check("abort_clear", {31'd0, SwitchAbort}, 32'd0);

        // Requests held high during DRAIN never restart it; reset lands in SWAP
        drive(0, 1, 1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 1, 0, 0);
            check("rereq_busy", {31'd0, Busy},      32'd1);
            check("rereq_ack",  {31'd0, SwitchAck}, 32'd0);
        end
        drive(1, 1, 1, 0, 0);
        check("rereq_swap_ack", {31'd0, SwitchAck}, 32'd1);
        idle();
        check("rst_swap_arm",   {31'd0, arm},         32'd0);
        check("rst_swap_busy",  {31'd0, Busy},        32'd0);
        check("rst_swap_stall", {31'd0, StallF},      32'd0);
        check("rst_swap_flush", {31'd0, FlushD},      32'd0);
        check("rst_swap_ack",   {31'd0, SwitchAck},   32'd0);
        check("rst_swap_abort", {31'd0, SwitchAbort}, 32'd0);

`ifdef COMBI_SWITCH_CNT_EN
        // Three switches, one no-op and one abort leave a count of 3
        do_switch(1);
        do_switch(0);
        do_switch(1);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        idle();
        drive(0, 0, 0, 0, 1);
        idle();
        check("cnt_three", {16'd0, SwitchCount}, 32'd3);
        // Saturation
        force dut.switch_cnt = 16'hFFFF;
        m_cnt = 65535;
        #1 release dut.switch_cnt;
        do_switch(0);
        idle();
        check("cnt_sat", {16'd0, SwitchCount}, 32'h0000FFFF);
`endif

        idle();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
